// File: rtl/vsource_mc.sv
// Multi-channel virtual signal source: pulse/square/ramp plus LFSR noise.
// Ports: clk, reset, cfg_* write port, dv_out, trig_out[NCH], d_out[NCH*DW].
module vsource_mc #(
  parameter int          NCH   = 4,
  parameter int          DW    = 18,
  parameter int          DECIM = 8,
  parameter logic [31:0] SEED  = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [2:0]        cfg_sel,
  input  logic [15:0]       cfg_data,
  output logic [NCH-1:0]    trig_out,
  output logic              dv_out,
  output logic [NCH*DW-1:0] d_out
);

  localparam int CW = $clog2(DECIM);

  function automatic logic [DW-1:0] sat(input logic [DW:0] x);
    if (x[DW] != x[DW-1])
      return x[DW] ? {1'b1, {(DW-1){1'b0}}}
                   : {1'b0, {(DW-1){1'b1}}};
    return x[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] ext17(input logic [16:0] x);
    return {{(DW-17){x[16]}}, x};
  endfunction

  logic [CW-1:0] div_q;
  logic          tick;
  logic          v1_q;

  assign tick = (div_q == CW'(DECIM - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      v1_q   <= 1'b0;
      dv_out <= 1'b0;
    end else begin
      div_q  <= tick ? '0 : div_q + CW'(1);
      v1_q   <= tick;
      dv_out <= v1_q;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [31:0] S0 = SEED ^ (32'(c) * 32'h9E37_79B9);
    localparam logic [31:0] S  = (S0 == 32'd0) ? 32'd1 : S0;

    logic [2:0]    ctrl_q, ctrl_d;
    logic [15:0]   per_q, per_d, wid_q, wid_d;
    logic [15:0]   amp_q, amp_d, nam_q, nam_d;
    logic          hit, en, hi;
    logic [1:0]    mode;
    logic [15:0]   ph_q;
    logic [31:0]   lfsr_q;
    logic [DW-1:0] acc_q, wave, w1_q, lane_q;
    logic [16:0]   a17, n17, nz_d, nz1_q;
    logic signed [31:0] lf32, na32;
    logic [DW:0]   rsum, osum;
    logic          t1_q, trig_q;

    assign hit = cfg_wr && (cfg_ch == 4'(c));

    // A write on the tick clock is seen by that tick.
    always_comb begin
      ctrl_d = ctrl_q;
      per_d  = per_q;
      wid_d  = wid_q;
      amp_d  = amp_q;
      nam_d  = nam_q;
      if (hit) begin
        case (cfg_sel)
          3'd0:    ctrl_d = cfg_data[2:0];
          3'd1:    per_d  = cfg_data;
          3'd2:    wid_d  = cfg_data;
          3'd3:    amp_d  = cfg_data;
          3'd4:    nam_d  = cfg_data;
          default: ;
        endcase
      end
    end

    assign en   = ctrl_d[0];
    assign mode = ctrl_d[2:1];
    assign hi   = ph_q < wid_d;
    assign a17  = {amp_d[15], amp_d};
    assign n17  = -a17;

    always_comb begin
      wave = '0;
      if (en) begin
        case (mode)
          2'd1:    if (hi) wave = ext17(a17);
          2'd2:    wave = hi ? ext17(a17) : ext17(n17);
          2'd3:    if (ph_q != 16'd0) wave = acc_q;
          default: ;
        endcase
      end
    end

    assign rsum = {wave[DW-1], wave} + {{(DW-16){a17[16]}}, a17};
    assign lf32 = {{16{lfsr_q[15]}}, lfsr_q[15:0]};
    assign na32 = {{16{nam_d[15]}}, nam_d};
    assign nz_d = 17'((lf32 * na32) >>> 15);
    assign osum = {w1_q[DW-1], w1_q} + {{(DW-16){nz1_q[16]}}, nz1_q};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ctrl_q <= '0;
        per_q  <= '0;
        wid_q  <= '0;
        amp_q  <= '0;
        nam_q  <= '0;
        ph_q   <= '0;
        acc_q  <= '0;
        lfsr_q <= S;
        w1_q   <= '0;
        nz1_q  <= '0;
        t1_q   <= 1'b0;
        lane_q <= '0;
        trig_q <= 1'b0;
      end else begin
        ctrl_q <= ctrl_d;
        per_q  <= per_d;
        wid_q  <= wid_d;
        amp_q  <= amp_d;
        nam_q  <= nam_d;
        if (tick) begin
          lfsr_q <= {1'b0, lfsr_q[31:1]}
                  ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
          w1_q   <= wave;
          nz1_q  <= en ? nz_d : '0;
          t1_q   <= en && (ph_q == 16'd0);
          if (!en || ph_q == per_d) ph_q <= '0;
          else                      ph_q <= ph_q + 16'd1;
          acc_q  <= (en && mode == 2'd3) ? sat(rsum) : '0;
        end
        if (v1_q) begin
          lane_q <= sat(osum);
          trig_q <= t1_q;
        end else begin
          trig_q <= 1'b0;
        end
      end
    end

    assign d_out[c*DW +: DW] = lane_q;
    assign trig_out[c]       = trig_q;
  end

endmodule

// File: tb/tb_vsource_mc.sv
// Scoreboard bench for vsource_mc: tick-level reference model feeds a queue,
// a negedge monitor pops and compares on every dv_out.
module tb_vsource_mc;
  localparam int NCH = 4;
  localparam int DW = 18;
  localparam int DECIM = 8;

  logic clk = 0;
  logic reset = 0;
  logic cfg_wr = 0;
  logic [3:0] cfg_ch = 0;
  logic [2:0] cfg_sel = 0;
  logic [15:0] cfg_data = 0;
  logic [NCH-1:0] trig_out;
  logic dv_out;
  logic [NCH*DW-1:0] d_out;

  always #5 clk = ~clk;

  vsource_mc #(.NCH(NCH), .DW(DW), .DECIM(DECIM)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .trig_out(trig_out),
    .dv_out(dv_out), .d_out(d_out)
  );

  typedef struct {
    logic [NCH-1:0] trig;
    logic [NCH*DW-1:0] d;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [NCH*DW-1:0] last_d = '0;
  int m_ctrl[NCH], m_per[NCH], m_wid[NCH], m_amp[NCH];
  int m_nam[NCH], m_ph[NCH], m_acc[NCH];
  bit [31:0] m_lf[NCH];
  bit track3 = 0;
  int max3 = 0;

  task automatic check(string name, longint got, longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic int clampv(int x);
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  function automatic bit [31:0] seed_of(int c);
    bit [31:0] s;
    s = 32'hACE1_2468 ^ (32'(c) * 32'h9E37_79B9);
    return (s == 0) ? 32'd1 : s;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ctrl[c] = 0; m_per[c] = 0; m_wid[c] = 0; m_amp[c] = 0;
      m_nam[c] = 0; m_ph[c] = 0; m_acc[c] = 0;
      m_lf[c] = seed_of(c);
    end
    last_d = '0;
    q.delete();
  endfunction

  // One sample tick: the sample is taken at the phase before it advances.
  function automatic void model_tick();
    exp_t e;
    e.trig = '0;
    e.d = '0;
    for (int c = 0; c < NCH; c++) begin
      bit en;
      int mode, p, wave, noise, s;
      bit [15:0] lo;
      en = m_ctrl[c][0];
      mode = (m_ctrl[c] >> 1) & 3;
      p = m_ph[c];
      wave = 0;
      noise = 0;
      if (en) begin
        case (mode)
          1: wave = (p < m_wid[c]) ? m_amp[c] : 0;
          2: wave = (p < m_wid[c]) ? m_amp[c] : -m_amp[c];
          3: wave = (p == 0) ? 0 : m_acc[c];
          default: wave = 0;
        endcase
        lo = m_lf[c][15:0];
        noise = (int'(shortint'(lo)) * m_nam[c]) >>> 15;
      end
      s = clampv(wave + noise);
      e.d[c*DW +: DW] = DW'(s);
      e.trig[c] = en && (p == 0);
      m_acc[c] = (en && mode == 3) ? clampv(wave + m_amp[c]) : 0;
      if (!en || p == m_per[c]) m_ph[c] = 0;
      else m_ph[c] = (p + 1) % 65536;
      m_lf[c] = {1'b0, m_lf[c][31:1]}
              ^ (m_lf[c][0] ? 32'h8020_0003 : 32'h0);
    end
    q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cfg_wr = 0;
    if (!reset) begin
      cyc++;
      if (cyc % DECIM == 0) model_tick();
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic wr(int ch, int sel, int data);
    cfg_wr = 1;
    cfg_ch = ch[3:0];
    cfg_sel = sel[2:0];
    cfg_data = data[15:0];
    if (ch < NCH) begin
      case (sel)
        0: m_ctrl[ch] = data & 7;
        1: m_per[ch] = data & 16'hFFFF;
        2: m_wid[ch] = data & 16'hFFFF;
        3: m_amp[ch] = int'(shortint'(cfg_data));
        4: m_nam[ch] = int'(shortint'(cfg_data));
        default: ;
      endcase
    end
    step();
  endtask

  task automatic rand_wr();
    int ch, sel, data;
    ch = $urandom_range(0, 5);
    sel = $urandom_range(0, 7);
    data = $urandom;
    if ((sel == 1 || sel == 2) && $urandom_range(0, 3) != 0)
      data = $urandom_range(0, 12);
    wr(ch, sel, data & 16'hFFFF);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_dv"}, dv_out, 0);
    check({tag, "_trig"}, trig_out, 0);
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s_lane%0d", tag, c),
            $signed(d_out[c*DW +: DW]), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("dv", dv_out, (cyc >= DECIM + 1 && cyc % DECIM == 1));
      if (dv_out) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow got=dv want=none cyc=%0d", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("trig", trig_out, e.trig);
          for (int c = 0; c < NCH; c++)
            check($sformatf("lane%0d", c),
                  $signed(d_out[c*DW +: DW]),
                  $signed(e.d[c*DW +: DW]));
          last_d = e.d;
          if (track3) begin
            int v;
            v = $signed(d_out[3*DW +: DW]);
            if (v < 0) v = -v;
            if (v > max3) max3 = v;
          end
        end
      end else begin
        check("trig_idle", trig_out, 0);
        total++;
        if (d_out !== last_d) begin
          bad++;
          $display("FAIL hold got=%h want=%h", d_out, last_d);
        end
      end
    end
  end

  initial begin
    model_reset();
    #2 reset = 1;
    #1 check_zero("rst");
    repeat (2) @(posedge clk);
    #1 reset = 0;
    cyc = 0;

    run(40);

    wr(0, 1, 9); wr(0, 2, 3); wr(0, 3, 1000); wr(0, 4, 0);
    wr(0, 0, 3);
    run(200);

    wr(1, 1, 3); wr(1, 2, 2); wr(1, 3, 16'h8000); wr(1, 0, 5);
    run(100);

    wr(2, 1, 16'hFFFF); wr(2, 3, 16'h7FFF); wr(2, 0, 7);
    run(80);

    wr(3, 3, 0); wr(3, 4, 16'h7FFF); wr(3, 0, 3);
    track3 = 1;
    run(8000);
    track3 = 0;
    check("noise_nosat", int'(max3 <= 32768), 1);
    wr(3, 4, 0);
    run(100);

    while (cyc % DECIM != 3) step();
    wr(0, 0, 0);
    run(40);
    wr(0, 0, 3);
    run(30);
    while (cyc % DECIM != 0) step();
    #1 reset = 1;
    #1 check_zero("midrst");
    model_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    run(30);

    repeat (4800) begin
      if ($urandom_range(0, 5) == 0) rand_wr();
      else step();
    end

    while (cyc % DECIM != 2) step();
    check("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
